// File: rtl/cache_line_ctrl.sv
`timescale 1ns/1ps
// cache_line_ctrl: miss sequencer that writes back a dirty victim line, then refills the missing line.
// Latency: a clean miss gives done W+1 cycles after the accept edge; a dirty miss gives done 2W+1 cycles after it.
// Backpressure: none. req is sampled only in IDLE, and a req held high while busy is ignored.
// Optional feature: define CACHE_CWF_EN for critical-word-first refill order.
// Ports:
//   CLK, RST (async, active-high)
//   req, req_addr, victim_dirty, victim_addr            miss request, sampled in IDLE
//   victim_idx / victim_data                            victim word read port of the cache array
//   fill_we, fill_idx, fill_data                        refill write port of the cache array
//   busy, done                                          status
//   MRd (active-low), CMWr, Addr, MDataIn / MDataOut    word RAM port; this block is its only master
module cache_line_ctrl #(
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              req,
    input  logic [ADDR_W-1:0]                 req_addr,
    input  logic                              victim_dirty,
    input  logic [ADDR_W-1:0]                 victim_addr,
    output logic [$clog2(WORDS_PER_LINE)-1:0] victim_idx,
    input  logic [31:0]                       victim_data,
    output logic                              fill_we,
    output logic [$clog2(WORDS_PER_LINE)-1:0] fill_idx,
    output logic [31:0]                       fill_data,
    output logic                              busy,
    output logic                              done,
    output logic                              MRd,
    output logic                              CMWr,
    output logic [ADDR_W-1:0]                 Addr,
    output logic [31:0]                       MDataIn,
    input  logic [31:0]                       MDataOut
);

    localparam int IDX_W = $clog2(WORDS_PER_LINE);
    // Byte-offset bits inside one line: word index plus the 2 byte bits.
    localparam int OFF_W = IDX_W + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_k;
    logic [IDX_W-1:0]  w_k_nxt;
    logic              w_accept;
    logic              w_last;
    logic [IDX_W-1:0]  w_fidx;
    logic [ADDR_W-1:0] r_wb_base;
    logic [ADDR_W-1:0] r_fill_base;

    // The in-line offset bits of both addresses are dropped when the line bases
    // are formed; this sink makes that intent explicit.
    logic w_unused_lsbs;
    assign w_unused_lsbs = ^{req_addr[OFF_W-1:0], victim_addr[OFF_W-1:0]};

    assign w_last = (r_k == IDX_W'(WORDS_PER_LINE - 1));

`ifdef CACHE_CWF_EN
    // Word index of the missing word; the fill starts there and wraps within the line.
    logic [IDX_W-1:0] r_crit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_crit <= '0;
        end else if (w_accept) begin
            r_crit <= req_addr[OFF_W-1:2];
        end
    end

    // Natural IDX_W-bit wrap gives the modulo-W rotation.
    assign w_fidx = r_crit + r_k;
`else
    assign w_fidx = r_k;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_wb_base   <= '0;
            r_fill_base <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            if (w_accept) begin
                r_wb_base   <= {victim_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                r_fill_base <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            end
        end
    end

    // All strobes decode the registered state only, so an async reset drops
    // CMWr and fill_we immediately without waiting for a clock edge.
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_accept    = 1'b0;
        MRd         = 1'b1;
        CMWr        = 1'b0;
        Addr        = '0;
        MDataIn     = '0;
        fill_we     = 1'b0;
        victim_idx  = '0;
        fill_idx    = '0;
        busy        = 1'b0;
        done        = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_k_nxt = '0;
                if (req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = victim_dirty ? S_WB : S_FILL;
                end
            end
            S_WB: begin
                busy       = 1'b1;
                CMWr       = 1'b1;
                victim_idx = r_k;
                Addr       = r_wb_base + ADDR_W'({r_k, 2'b00});
                MDataIn    = victim_data;
                if (w_last) begin
                    w_k_nxt     = '0;
                    w_state_nxt = S_FILL;
                end else begin
                    w_k_nxt = r_k + IDX_W'(1);
                end
            end
            S_FILL: begin
                busy     = 1'b1;
                MRd      = 1'b0;
                fill_we  = 1'b1;
                fill_idx = w_fidx;
                Addr     = r_fill_base + ADDR_W'({w_fidx, 2'b00});
                if (w_last) begin
                    w_k_nxt     = '0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_k_nxt = r_k + IDX_W'(1);
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign fill_data = MDataOut;

endmodule
